tc_serial_tx: RTL and testbench

//  Bit-serial transmitter that feeds the serial two's-complement datapath.
//  - Accepts a parallel W-bit word over a valid/ready handshake.
//  - Shifts the word out LSB-first, one bit per clock.
//  - Optionally negates the word on the fly (pass bits up to and including the first 1, invert the rest).
//  - Emits sof/eof frame strobes; downstream serial logic uses sof as its per-word restart.

---
 rtl/tc_pkg.sv | 15 +
 rtl/tc_neg_cell.sv | 25 ++
 rtl/tc_serial_tx.sv | 88 ++++++++
 tb/tb_tc_serial_tx.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/tc_pkg.sv
// Shared definitions for the bit-serial two's-complement datapath blocks.
package tc_pkg;

  localparam int TC_W = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } tc_state_e;

  function automatic int tc_cnt_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/tc_neg_cell.sv
// Serial two's-complement negation cell: pass bits through the first 1, invert the rest.
module tc_neg_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic bin,
  input  logic neg,
  output logic bout
);

  logic seen_one;

  // clr wins over en so a word loaded on the last bit of the previous one starts clean
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      seen_one <= 1'b0;
    end else if (en) begin
      seen_one <= seen_one | bin;
    end
  end

  assign bout = neg ? (bin ^ seen_one) : bin;

endmodule

// File: rtl/tc_serial_tx.sv
// LSB-first serial transmitter with optional on-the-fly negation and sof/eof framing.
module tc_serial_tx
  import tc_pkg::*;
#(
  parameter int W      = TC_W,
  parameter bit NEG_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  input  logic         neg,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         sout,
  output logic         sout_valid,
  output logic         sof,
  output logic         eof,
  output logic         busy
);

  localparam int CW = tc_cnt_w(W);

  tc_state_e      state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   shreg;
  logic           neg_q;
  logic           cnt_last;
  logic           load_fire;
  logic           shifting;
  logic           cell_bout;

  assign shifting  = (state == ST_SHIFT);
  assign cnt_last  = (cnt == CW'(W - 1));
  assign load_fire = load_valid && load_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      shreg <= '0;
      neg_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_fire) begin
        shreg <= din;
        neg_q <= neg && NEG_EN;
        cnt   <= '0;
      end else if (shifting) begin
        shreg <= shreg >> 1;
        cnt   <= cnt_last ? '0 : cnt + CW'(1);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        load_ready = 1'b1;
        if (load_valid) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        load_ready = cnt_last;
        if (cnt_last && !load_valid) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  tc_neg_cell u_neg (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (load_fire),
    .en    (shifting),
    .bin   (shreg[0]),
    .neg   (neg_q),
    .bout  (cell_bout)
  );

  // seen_one is left set after a negated word, so gate the bit outside SHIFT
  assign sout       = shifting & cell_bout;
  assign sout_valid = shifting;
  assign busy       = shifting;
  assign sof        = shifting && (cnt == '0);
  assign eof        = shifting && cnt_last;

endmodule

// File: tb/tb_tc_serial_tx.sv
// Bench for tc_serial_tx: NEG_EN=1 and NEG_EN=0 instances share stimulus against a word-level model.
module tb_tc_serial_tx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] din = '0;
  logic         neg = 1'b0;
  logic         load_valid = 1'b0;

  logic load_ready1, sout1, sout_valid1, sof1, eof1, busy1;
  logic load_ready0, sout0, sout_valid0, sof0, eof0, busy0;

  tc_serial_tx #(.W(W), .NEG_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .neg(neg), .load_valid(load_valid),
    .load_ready(load_ready1), .sout(sout1), .sout_valid(sout_valid1),
    .sof(sof1), .eof(eof1), .busy(busy1)
  );

  tc_serial_tx #(.W(W), .NEG_EN(1'b0)) dut_nn (
    .clk(clk), .rst_n(rst_n), .din(din), .neg(neg), .load_valid(load_valid),
    .load_ready(load_ready0), .sout(sout0), .sout_valid(sout_valid0),
    .sof(sof0), .eof(eof0), .busy(busy0)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // word-level model: bits still to be shown, and the words each instance should send
  int           rem = 0;
  logic [W-1:0] w1 = '0;
  logic [W-1:0] w0 = '0;
  bit           model_init = 0;
  bit           last_acc = 0;

  logic [W-1:0] asm1 = '0, asm0 = '0;
  logic [W-1:0] last_word1 = '0, last_word0 = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic step();
    logic         acc;
    logic         ebit1, ebit0;
    logic [W-1:0] negd;
    if (model_init) begin
      chk("ready1", load_ready1, rem <= 1);
      chk("ready0", load_ready0, rem <= 1);
    end
    acc  = rst_n && load_valid && (rem <= 1);
    negd = -din;
    @(posedge clk);
    model_init = 1;
    last_acc   = acc;
    if (!rst_n) rem = 0;
    else if (acc) begin
      rem = W;
      w1  = neg ? negd : din;
      w0  = din;
    end else if (rem > 0) rem--;
    #1;
    ebit1 = (rem > 0) ? w1[W-rem] : 1'b0;
    ebit0 = (rem > 0) ? w0[W-rem] : 1'b0;
    chk("valid1", sout_valid1, rem > 0);
    chk("valid0", sout_valid0, rem > 0);
    chk("busy1", busy1, rem > 0);
    chk("busy0", busy0, rem > 0);
    chk("sof1", sof1, rem == W);
    chk("sof0", sof0, rem == W);
    chk("eof1", eof1, rem == 1);
    chk("eof0", eof0, rem == 1);
    chk("sout1", sout1, ebit1);
    chk("sout0", sout0, ebit0);
    if (sout_valid1) asm1 = {sout1, asm1[W-1:1]};
    if (sout_valid0) asm0 = {sout0, asm0[W-1:1]};
    if (eof1) last_word1 = asm1;
    if (eof0) last_word0 = asm0;
  endtask

  task automatic send(input logic [W-1:0] d, input logic n);
    din = d;
    neg = n;
    load_valid = 1'b1;
    for (int i = 0; i < 4 * W; i++) begin
      step();
      if (last_acc) return;
    end
    chk("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    load_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // reset held with a pending load
    rst_n = 1'b0; load_valid = 1'b1; din = 8'h5A; neg = 1'b1;
    repeat (3) step();
    rst_n = 1'b1; load_valid = 1'b0;
    step();
    chk("rst_ready", load_ready1, 1);
    chk("rst_busy", busy1, 0);

    send(8'h05, 1'b1); idle(W + 1);
    chk("w05n_neg", last_word1, 8'hFB);
    chk("w05n_raw", last_word0, 8'h05);

    send(8'hA6, 1'b0); idle(W + 1);
    chk("wA6", last_word1, 8'hA6);

    send(8'h00, 1'b1); idle(W + 1);
    chk("w00n", last_word1, 8'h00);

    send(8'h80, 1'b1); idle(W + 1);
    chk("w80n", last_word1, 8'h80);

    // back-to-back with load_valid held
    send(8'h01, 1'b1);
    send(8'h03, 1'b0);
    chk("b2b_prev", last_word1, 8'hFF);
    idle(W + 1);
    chk("b2b_last", last_word1, 8'h03);

    // reset during bit 3, then a fresh negated word
    send(8'h01, 1'b1);
    load_valid = 1'b0;
    repeat (3) step();
    rst_n = 1'b0; step();
    rst_n = 1'b1; step();
    send(8'h04, 1'b1); idle(W + 1);
    chk("post_rst", last_word1, 8'hFC);

    // mid-word input churn
    send(8'h05, 1'b1);
    load_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      din = $urandom; neg = $urandom;
      step();
    end
    idle(2);
    chk("churn1", last_word1, 8'hFB);
    chk("churn0", last_word0, 8'h05);

    // randomized traffic including occasional resets
    for (int i = 0; i < 600; i++) begin
      din        = $urandom;
      neg        = $urandom;
      load_valid = ($urandom_range(0, 9) < 7);
      rst_n      = ($urandom_range(0, 99) >= 2);
      step();
    end
    rst_n = 1'b1;
    idle(W + 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
